// File: rtl/door_lock_pkg.sv
// door_lock_pkg: state encodings and key constants for the PIN door lock.
// Shared by door_lock_ctrl and the display/LED block.
package door_lock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ENTRY    = 3'd1,
    ST_CHECK    = 3'd2,
    ST_UNLOCKED = 3'd3,
    ST_ERROR    = 3'd4,
    ST_LOCKOUT  = 3'd5,
    ST_PROG     = 3'd6
  } state_e;

  localparam logic [3:0] KEY_ENTER = 4'd8;
  localparam int         DIGIT_W   = 4;

  function automatic logic is_digit(input logic [3:0] k);
    return !k[3];
  endfunction

endpackage

// File: rtl/dl_timer.sv
// dl_timer: loadable down-counter; expired while the count is zero.
// A load of N-1 gives a hold of exactly N cycles.
module dl_timer #(
  parameter int unsigned TMR_W = 28
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [TMR_W-1:0] load_val_i,
  output logic             expired_o
);

  logic [TMR_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/door_lock_ctrl.sv
// door_lock_ctrl: PIN-entry sequencer with timed unlock/error/lockout holds.
// Define DOOR_LOCK_PIN_CHANGE_EN to enable PIN reprogramming while unlocked.
module door_lock_ctrl
  import door_lock_pkg::*;
#(
  parameter int unsigned                   PIN_LEN      = 4,
  parameter logic [PIN_LEN*DIGIT_W-1:0]    DEFAULT_PIN  = 16'h1234,
  parameter int unsigned                   MAX_FAIL     = 3,
  parameter int unsigned                   TMR_W        = 28,
  parameter int unsigned                   ENTRY_TO_CYC = 120_000_000,
  parameter int unsigned                   UNLOCK_CYC   = 72_000_000,
  parameter int unsigned                   ERR_CYC      = 24_000_000,
  parameter int unsigned                   LOCKOUT_CYC  = 240_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid_i,
  input  logic [3:0] key_idx_i,
  output logic       unlock_o,
  output logic       err_o,
  output logic       alarm_o,
  output logic [3:0] digit_cnt_o,
  output logic [2:0] fail_cnt_o,
  output logic [2:0] state_o
);

  localparam int BW = PIN_LEN * DIGIT_W;
  localparam logic [TMR_W-1:0] LD_ENT = TMR_W'(ENTRY_TO_CYC - 1);
  localparam logic [TMR_W-1:0] LD_UNL = TMR_W'(UNLOCK_CYC - 1);
  localparam logic [TMR_W-1:0] LD_ERR = TMR_W'(ERR_CYC - 1);
  localparam logic [TMR_W-1:0] LD_LCK = TMR_W'(LOCKOUT_CYC - 1);

  state_e          state_q, state_d;
  logic [BW-1:0]   ebuf_q, ebuf_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic [2:0]      fail_q, fail_d;
  logic            unlock_q, err_q, alarm_q;
  logic [BW-1:0]   pin_w;
  logic            tmr_load, tmr_exp;
  logic [TMR_W-1:0] tmr_val;

  logic            key_dig, key_ent, full, match;
  logic [3:0]      digit;
  logic [2:0]      fail_inc;
  logic [BW-1:0]   ebuf_sh;

`ifdef DOOR_LOCK_PIN_CHANGE_EN
  logic [BW-1:0]   pin_q, pin_d;
  assign pin_w = pin_q;
`else
  assign pin_w = DEFAULT_PIN;
`endif

  assign key_dig  = key_valid_i && is_digit(key_idx_i);
  assign key_ent  = key_valid_i && (key_idx_i == KEY_ENTER);
  assign digit    = {1'b0, key_idx_i[2:0]} + 4'd1;
  assign full     = (cnt_q == 4'(PIN_LEN));
  assign ebuf_sh  = (ebuf_q << DIGIT_W) | BW'(digit);
  assign fail_inc = fail_q + 3'd1;
  assign match    = full && !ovf_q && (ebuf_q == pin_w);

  dl_timer #(.TMR_W(TMR_W)) u_tmr (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expired_o  (tmr_exp)
  );

  always_comb begin
    state_d  = state_q;
    ebuf_d   = ebuf_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    fail_d   = fail_q;
    tmr_load = 1'b0;
    tmr_val  = LD_ENT;
`ifdef DOOR_LOCK_PIN_CHANGE_EN
    pin_d    = pin_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (key_dig) begin
          ebuf_d   = BW'(digit);
          cnt_d    = 4'd1;
          ovf_d    = 1'b0;
          tmr_load = 1'b1;
          state_d  = ST_ENTRY;
        end
      end
      ST_ENTRY, ST_PROG: begin
        // a key in the timeout cycle wins over the timeout
        if (key_dig) begin
          ebuf_d   = ebuf_sh;
          cnt_d    = full ? cnt_q : cnt_q + 4'd1;
          ovf_d    = ovf_q | full;
          tmr_load = 1'b1;
        end else if (key_ent && state_q == ST_ENTRY) begin
          state_d = ST_CHECK;
        end else if (key_ent || tmr_exp) begin
`ifdef DOOR_LOCK_PIN_CHANGE_EN
          if (key_ent && full && !ovf_q) pin_d = ebuf_q;
`endif
          ebuf_d  = '0;
          cnt_d   = 4'd0;
          ovf_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: begin
        ebuf_d   = '0;
        cnt_d    = 4'd0;
        ovf_d    = 1'b0;
        tmr_load = 1'b1;
        if (match) begin
          fail_d  = 3'd0;
          tmr_val = LD_UNL;
          state_d = ST_UNLOCKED;
        end else if (fail_inc == 3'(MAX_FAIL)) begin
          fail_d  = fail_inc;
          tmr_val = LD_LCK;
          state_d = ST_LOCKOUT;
        end else begin
          fail_d  = fail_inc;
          tmr_val = LD_ERR;
          state_d = ST_ERROR;
        end
      end
      ST_UNLOCKED: begin
        if (tmr_exp) begin
          state_d = ST_IDLE;
        end else if (key_ent) begin
`ifdef DOOR_LOCK_PIN_CHANGE_EN
          tmr_load = 1'b1;
          state_d  = ST_PROG;
`else
          state_d  = ST_IDLE;
`endif
        end
      end
      ST_ERROR: begin
        if (tmr_exp) state_d = ST_IDLE;
      end
      ST_LOCKOUT: begin
        if (tmr_exp) begin
          fail_d  = 3'd0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ebuf_q   <= '0;
      cnt_q    <= 4'd0;
      ovf_q    <= 1'b0;
      fail_q   <= 3'd0;
      unlock_q <= 1'b0;
      err_q    <= 1'b0;
      alarm_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ebuf_q   <= ebuf_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      fail_q   <= fail_d;
      unlock_q <= (state_d == ST_UNLOCKED) || (state_d == ST_PROG);
      err_q    <= (state_d == ST_ERROR);
      alarm_q  <= (state_d == ST_LOCKOUT);
    end
  end

`ifdef DOOR_LOCK_PIN_CHANGE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pin_q <= DEFAULT_PIN;
    else     pin_q <= pin_d;
  end
`endif

  assign unlock_o    = unlock_q;
  assign err_o       = err_q;
  assign alarm_o     = alarm_q;
  assign digit_cnt_o = cnt_q;
  assign fail_cnt_o  = fail_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_door_lock_ctrl.sv
// tb_door_lock_ctrl: directed scenarios plus random keys vs a queue-based model.
// Short timers: entry 50, unlock 20, error 10, lockout 30 cycles; PIN 1234.
module tb_door_lock_ctrl;
  import door_lock_pkg::*;

  localparam int T_ENT = 50;
  localparam int T_UNL = 20;
  localparam int T_ERR = 10;
  localparam int T_LCK = 30;
  localparam int PLEN  = 4;
  localparam int MAXF  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid_i = 1'b0;
  logic [3:0] key_idx_i = 4'd0;
  logic       unlock_o, err_o, alarm_o;
  logic [3:0] digit_cnt_o;
  logic [2:0] fail_cnt_o, state_o;

  int n_chk = 0;
  int n_pass = 0;

  door_lock_ctrl #(
    .TMR_W(28), .ENTRY_TO_CYC(T_ENT), .UNLOCK_CYC(T_UNL),
    .ERR_CYC(T_ERR), .LOCKOUT_CYC(T_LCK)
  ) dut (
    .clk(clk), .rst(rst), .key_valid_i(key_valid_i), .key_idx_i(key_idx_i),
    .unlock_o(unlock_o), .err_o(err_o), .alarm_o(alarm_o),
    .digit_cnt_o(digit_cnt_o), .fail_cnt_o(fail_cnt_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // reference model: mode + absolute deadline, digits and PIN as queues
  state_e m_mode;
  int     m_t, m_until, m_fail;
  bit     m_ovf;
  int     m_dig[$];
  int     m_pin[$];

  function automatic void m_reset();
    m_mode = ST_IDLE; m_t = 0; m_until = 0; m_fail = 0; m_ovf = 0;
    m_dig.delete(); m_pin.delete();
    for (int i = 0; i < PLEN; i++) m_pin.push_back(i + 1);
  endfunction

  function automatic bit m_pin_ok();
    if (m_dig.size() != PLEN || m_ovf) return 0;
    for (int i = 0; i < PLEN; i++) if (m_dig[i] != m_pin[i]) return 0;
    return 1;
  endfunction

  function automatic void m_step(input logic kv, input logic [3:0] ki);
    bit dig, ent;
    m_t++;
    dig = kv && (ki < 4'd8);
    ent = kv && (ki == 4'd8);
    case (m_mode)
      ST_IDLE: if (dig) begin
        m_dig.delete(); m_dig.push_back(int'(ki) + 1); m_ovf = 0;
        m_mode = ST_ENTRY; m_until = m_t + T_ENT;
      end
      ST_ENTRY, ST_PROG: begin
        if (dig) begin
          if (m_dig.size() < PLEN) m_dig.push_back(int'(ki) + 1);
          else m_ovf = 1;
          m_until = m_t + T_ENT;
        end else if (ent && m_mode == ST_ENTRY) begin
          m_mode = ST_CHECK;
        end else if (ent || m_t >= m_until) begin
          if (ent && m_dig.size() == PLEN && !m_ovf) m_pin = m_dig;
          m_dig.delete(); m_ovf = 0; m_mode = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (m_pin_ok()) begin
          m_fail = 0; m_mode = ST_UNLOCKED; m_until = m_t + T_UNL;
        end else begin
          m_fail++;
          if (m_fail == MAXF) begin m_mode = ST_LOCKOUT; m_until = m_t + T_LCK; end
          else begin m_mode = ST_ERROR; m_until = m_t + T_ERR; end
        end
        m_dig.delete(); m_ovf = 0;
      end
      ST_UNLOCKED: begin
        if (m_t >= m_until) m_mode = ST_IDLE;
        else if (ent) begin
`ifdef DOOR_LOCK_PIN_CHANGE_EN
          m_mode = ST_PROG; m_until = m_t + T_ENT;
`else
          m_mode = ST_IDLE;
`endif
        end
      end
      ST_ERROR: if (m_t >= m_until) m_mode = ST_IDLE;
      ST_LOCKOUT: if (m_t >= m_until) begin m_fail = 0; m_mode = ST_IDLE; end
      default: ;
    endcase
  endfunction

  task automatic cyc(input logic kv, input logic [3:0] ki);
    @(negedge clk);
    key_valid_i = kv; key_idx_i = ki;
    @(posedge clk);
    m_step(kv, ki);
    #1;
    key_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 4'd0);
  endtask

  task automatic pin_enter(input int a, input int b, input int c, input int d);
    cyc(1'b1, 4'(a)); cyc(1'b1, 4'(b)); cyc(1'b1, 4'(c)); cyc(1'b1, 4'(d));
    cyc(1'b1, KEY_ENTER);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; key_valid_i = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && state_o != ST_IDLE; i++) idle(1);
  endtask

  task automatic test_reset();
    apply_reset();
    cyc(1'b1, 4'd0); cyc(1'b1, 4'd1);
    n_chk++; if (digit_cnt_o !== 4'd2) $display("FAIL pre_rst_cnt got=%0d want=2", digit_cnt_o); else n_pass++;
    @(negedge clk); rst = 1'b1; m_reset(); #1;
    n_chk++; if (state_o !== ST_IDLE) $display("FAIL rst_state got=%0d want=0", state_o); else n_pass++;
    n_chk++; if (digit_cnt_o !== 4'd0) $display("FAIL rst_cnt got=%0d want=0", digit_cnt_o); else n_pass++;
    n_chk++; if (fail_cnt_o !== 3'd0) $display("FAIL rst_fail got=%0d want=0", fail_cnt_o); else n_pass++;
    n_chk++; if ({unlock_o, err_o, alarm_o} !== 3'b000) $display("FAIL rst_outs got=%b want=000", {unlock_o, err_o, alarm_o}); else n_pass++;
    @(posedge clk); #1 rst = 1'b0;
    idle(2);
    n_chk++; if (state_o !== ST_IDLE) $display("FAIL post_rst_state got=%0d want=0", state_o); else n_pass++;
  endtask

  task automatic test_unlock();
    int n;
    apply_reset();
    pin_enter(0, 1, 2, 3);
    n_chk++; if (state_o !== ST_CHECK) $display("FAIL unl_check got=%0d want=%0d", state_o, ST_CHECK); else n_pass++;
    n_chk++; if (unlock_o !== 1'b0) $display("FAIL unl_early got=%b want=0", unlock_o); else n_pass++;
    idle(1);
    n_chk++; if (unlock_o !== 1'b1) $display("FAIL unl_start got=%b want=1", unlock_o); else n_pass++;
    n = 1;
    for (int i = 0; i < 40 && unlock_o; i++) begin idle(1); if (unlock_o) n++; end
    n_chk++; if (n != T_UNL) $display("FAIL unl_len got=%0d want=%0d", n, T_UNL); else n_pass++;
    n_chk++; if (fail_cnt_o !== 3'd0) $display("FAIL unl_fail got=%0d want=0", fail_cnt_o); else n_pass++;
  endtask

  task automatic test_error();
    int n;
    apply_reset();
    pin_enter(0, 1, 2, 4);
    idle(1);
    n_chk++; if (err_o !== 1'b1) $display("FAIL err_start got=%b want=1", err_o); else n_pass++;
    n = 1;
    for (int i = 0; i < 40 && err_o; i++) begin idle(1); if (err_o) n++; end
    n_chk++; if (n != T_ERR) $display("FAIL err_len got=%0d want=%0d", n, T_ERR); else n_pass++;
    n_chk++; if (fail_cnt_o !== 3'd1) $display("FAIL err_fail got=%0d want=1", fail_cnt_o); else n_pass++;
    pin_enter(0, 1, 2, 3);
    idle(1);
    n_chk++; if (unlock_o !== 1'b1) $display("FAIL err_then_unl got=%b want=1", unlock_o); else n_pass++;
    n_chk++; if (fail_cnt_o !== 3'd0) $display("FAIL err_fail_clr got=%0d want=0", fail_cnt_o); else n_pass++;
    drain();
  endtask

  task automatic test_lockout();
    int n;
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      pin_enter(0, 1, 2, 4);
      idle(1);
      n_chk++; if (fail_cnt_o !== 3'(k + 1)) $display("FAIL lck_fail%0d got=%0d want=%0d", k, fail_cnt_o, k + 1); else n_pass++;
      drain();
    end
    pin_enter(0, 1, 2, 4);
    idle(1);
    n_chk++; if ({alarm_o, err_o} !== 2'b10) $display("FAIL lck_start got=%b want=10", {alarm_o, err_o}); else n_pass++;
    n = 1;
    for (int i = 0; i < 60 && alarm_o; i++) begin
      cyc(1'b1, 4'($urandom_range(0, 8)));
      if (alarm_o) n++;
    end
    n_chk++; if (n != T_LCK) $display("FAIL lck_len got=%0d want=%0d", n, T_LCK); else n_pass++;
    n_chk++; if (state_o !== ST_IDLE) $display("FAIL lck_end_state got=%0d want=0", state_o); else n_pass++;
    n_chk++; if (fail_cnt_o !== 3'd0) $display("FAIL lck_end_fail got=%0d want=0", fail_cnt_o); else n_pass++;
    n_chk++; if (digit_cnt_o !== 4'd0) $display("FAIL lck_end_cnt got=%0d want=0", digit_cnt_o); else n_pass++;
  endtask

  task automatic test_timeout();
    apply_reset();
    pin_enter(0, 1, 2, 4);
    drain();
    cyc(1'b1, 4'd0); cyc(1'b1, 4'd1);
    idle(T_ENT - 1);
    n_chk++; if (state_o !== ST_ENTRY) $display("FAIL to_before got=%0d want=%0d", state_o, ST_ENTRY); else n_pass++;
    idle(1);
    n_chk++; if (state_o !== ST_IDLE) $display("FAIL to_state got=%0d want=0", state_o); else n_pass++;
    n_chk++; if (digit_cnt_o !== 4'd0) $display("FAIL to_cnt got=%0d want=0", digit_cnt_o); else n_pass++;
    n_chk++; if (fail_cnt_o !== 3'd1) $display("FAIL to_fail got=%0d want=1", fail_cnt_o); else n_pass++;
    cyc(1'b1, 4'd0); cyc(1'b1, 4'd1);
    idle(T_ENT - 1);
    cyc(1'b1, 4'd2);
    n_chk++; if (state_o !== ST_ENTRY) $display("FAIL to_keywins got=%0d want=%0d", state_o, ST_ENTRY); else n_pass++;
    n_chk++; if (digit_cnt_o !== 4'd3) $display("FAIL to_keycnt got=%0d want=3", digit_cnt_o); else n_pass++;
  endtask

  task automatic test_length();
    apply_reset();
    cyc(1'b1, 4'd0); cyc(1'b1, 4'd1); cyc(1'b1, 4'd2); cyc(1'b1, 4'd3); cyc(1'b1, 4'd4);
    n_chk++; if (digit_cnt_o !== 4'd4) $display("FAIL len_sat got=%0d want=4", digit_cnt_o); else n_pass++;
    cyc(1'b1, KEY_ENTER); idle(1);
    n_chk++; if (err_o !== 1'b1) $display("FAIL len_ovf got=%b want=1", err_o); else n_pass++;
    drain();
    cyc(1'b1, 4'd0); cyc(1'b1, 4'd1); cyc(1'b1, 4'd2); cyc(1'b1, KEY_ENTER); idle(1);
    n_chk++; if (err_o !== 1'b1) $display("FAIL len_short got=%b want=1", err_o); else n_pass++;
    drain();
    cyc(1'b1, KEY_ENTER); idle(1);
    n_chk++; if (state_o !== ST_IDLE) $display("FAIL len_lone_ent got=%0d want=0", state_o); else n_pass++;
    n_chk++; if (fail_cnt_o !== 3'd2) $display("FAIL len_fail got=%0d want=2", fail_cnt_o); else n_pass++;
  endtask

  task automatic test_pin_change();
    apply_reset();
    pin_enter(0, 1, 2, 3);
    idle(1);
    cyc(1'b1, KEY_ENTER);
`ifdef DOOR_LOCK_PIN_CHANGE_EN
    n_chk++; if ({state_o, unlock_o} !== {ST_PROG, 1'b1}) $display("FAIL pc_prog got=%0d/%b want=%0d/1", state_o, unlock_o, ST_PROG); else n_pass++;
    pin_enter(4, 4, 4, 4);
    n_chk++; if ({state_o, unlock_o} !== {ST_IDLE, 1'b0}) $display("FAIL pc_done got=%0d/%b want=0/0", state_o, unlock_o); else n_pass++;
    pin_enter(0, 1, 2, 3); idle(1);
    n_chk++; if (err_o !== 1'b1) $display("FAIL pc_old_pin got=%b want=1", err_o); else n_pass++;
    drain();
    pin_enter(4, 4, 4, 4); idle(1);
    n_chk++; if (unlock_o !== 1'b1) $display("FAIL pc_new_pin got=%b want=1", unlock_o); else n_pass++;
    apply_reset();
    pin_enter(0, 1, 2, 3); idle(1);
    n_chk++; if (unlock_o !== 1'b1) $display("FAIL pc_rst_pin got=%b want=1", unlock_o); else n_pass++;
    drain();
`else
    n_chk++; if ({state_o, unlock_o} !== {ST_IDLE, 1'b0}) $display("FAIL pc_relock got=%0d/%b want=0/0", state_o, unlock_o); else n_pass++;
`endif
  endtask

  task automatic test_random();
    int pend[$];
    int r;
    logic kv;
    logic [3:0] ki;
    apply_reset();
    for (int i = 0; i < 2500; i++) begin
      if (i % 120 == 0) begin
        pend.delete();
        for (int j = 0; j < PLEN; j++) pend.push_back(j);
        pend.push_back(8);
      end
      if (pend.size() > 0) begin
        kv = 1'b1; ki = 4'(pend.pop_front());
      end else if ((i % 400) >= 330) begin
        kv = 1'b0; ki = 4'($urandom_range(0, 15));
      end else begin
        kv = ($urandom_range(0, 3) == 0);
        r  = $urandom_range(0, 9);
        ki = (r < 4) ? 4'(r) : (r < 7) ? 4'd8 : 4'($urandom_range(4, 15));
      end
      cyc(kv, ki);
      n_chk++; if (state_o !== 3'(m_mode)) $display("FAIL rnd_state t=%0d got=%0d want=%0d", m_t, state_o, m_mode); else n_pass++;
      n_chk++; if (unlock_o !== (m_mode == ST_UNLOCKED || m_mode == ST_PROG)) $display("FAIL rnd_unlock t=%0d got=%b", m_t, unlock_o); else n_pass++;
      n_chk++; if (err_o !== (m_mode == ST_ERROR)) $display("FAIL rnd_err t=%0d got=%b", m_t, err_o); else n_pass++;
      n_chk++; if (alarm_o !== (m_mode == ST_LOCKOUT)) $display("FAIL rnd_alarm t=%0d got=%b", m_t, alarm_o); else n_pass++;
      n_chk++; if (digit_cnt_o !== 4'(m_dig.size())) $display("FAIL rnd_cnt t=%0d got=%0d want=%0d", m_t, digit_cnt_o, m_dig.size()); else n_pass++;
      n_chk++; if (fail_cnt_o !== 3'(m_fail)) $display("FAIL rnd_fail t=%0d got=%0d want=%0d", m_t, fail_cnt_o, m_fail); else n_pass++;
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_unlock();
    test_error();
    test_lockout();
    test_timeout();
    test_length();
    test_pin_change();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired passed=%0d total=%0d", n_pass, n_chk);
    $fatal(1, "timeout");
  end

endmodule
